// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - CPU bus responder for on-chip RAM with wait states and an LED I/O register
module mem_bus_responder #(
  parameter int          ADDR_W      = 14,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              clk,
  input  logic              locked,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_rdata,
  output logic              m_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        led
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RLAT  = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_WDONE = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]        state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [15:0]       last_addr_q, last_addr_d;
  logic              wr_done_q,   wr_done_d;
  logic              force_rd_q,  force_rd_d;
  logic              m_ready_q,   m_ready_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q,    mem_we_d;
  logic [3:0]        led_q,       led_d;

  logic addr_changed;
  logic wr_done_eff;
  logic cur_is_io;
  logic last_is_io;

  // Address-change and write-done views of the current bus cycle; a dropped
  // write level or a new address re-arms the write in the same cycle so that
  // a simultaneous address change and write is treated as a write.
  always_comb begin
    addr_changed = (cpu_addr != last_addr_q);
    wr_done_eff  = wr_done_q && cpu_wr && !addr_changed;
    cur_is_io    = (cpu_addr == IO_ADDR);
    last_is_io   = (last_addr_q == IO_ADDR);
  end

  // Next-state and output-register logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    wr_done_d   = wr_done_eff;
    force_rd_d  = force_rd_q;
    m_ready_d   = m_ready_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    led_d       = led_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_wr && !wr_done_eff) begin
          if (cur_is_io) begin
            led_d = cpu_wdata[3:0];
          end else begin
            mem_addr_d  = cpu_addr[ADDR_W-1:0];
            mem_wdata_d = cpu_wdata;
            mem_we_d    = 1'b1;
          end
          cpu_rdata_d = cpu_wdata;
          last_addr_d = cpu_addr;
          m_ready_d   = 1'b0;
          cnt_d       = WAIT_INIT;
          state_d     = ST_WDONE;
        end else if (addr_changed || force_rd_q) begin
          m_ready_d   = 1'b0;
          mem_addr_d  = cpu_addr[ADDR_W-1:0];
          last_addr_d = cpu_addr;
          force_rd_d  = 1'b0;
          cnt_d       = WAIT_INIT;
          state_d     = ST_RLAT;
        end
      end

      ST_RLAT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CAPT: begin
        if (addr_changed) begin
          // CPU moved the address while we waited: restart on the new one
          // rather than hand back data for a stale address.
          m_ready_d   = 1'b0;
          mem_addr_d  = cpu_addr[ADDR_W-1:0];
          last_addr_d = cpu_addr;
          force_rd_d  = 1'b0;
          cnt_d       = WAIT_INIT;
          state_d     = ST_RLAT;
        end else begin
          cpu_rdata_d = last_is_io ? {4'h0, led_q} : mem_rdata;
          m_ready_d   = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_WDONE: begin
        mem_we_d = 1'b0;
        if (cnt_q == 4'd0) begin
          wr_done_d = 1'b1;
          m_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; locked low clears everything at once, even mid-access.
  always_ff @(posedge clk or negedge locked) begin
    if (!locked) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_addr_q <= 16'h0000;
      wr_done_q   <= 1'b0;
      force_rd_q  <= 1'b1;
      m_ready_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      led_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      wr_done_q   <= wr_done_d;
      force_rd_q  <= force_rd_d;
      m_ready_q   <= m_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      led_q       <= led_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign m_ready   = m_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized self-checking bench with a transaction-level reference model
`timescale 1ns/1ps
module tb_mem_bus_responder;

  localparam logic [15:0] IO_ADDR  = 16'hFFFF;
  localparam int          MAX_WAIT = 200;
  localparam int          N_RAND   = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [inst%0d] %s: got 0x%0h, expected 0x%0h", inst, name, act, exp);
    end
  endtask

  // Power-up RAM contents, shared by the RAM environment and the model.
  function automatic logic [7:0] ram_init(input logic [13:0] a);
    case (a)
      14'h0010: return 8'hA5;
      14'h0011: return 8'h3C;
      14'h0030: return 8'h5E;
      14'h0031: return 8'hC3;
      default:  return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h96;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int W      = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
    localparam int RD_LAT = 2 + W;
    localparam int WR_LAT = 1 + W;

    logic        locked;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        m_ready;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [3:0]  led;
    bit          done = 1'b0;

    mem_bus_responder #(
      .ADDR_W(14),
      .WAIT_STATES(W),
      .IO_ADDR(IO_ADDR)
    ) u_dut (
      .clk(clk),
      .locked(locked),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_wr(cpu_wr),
      .cpu_rdata(cpu_rdata),
      .m_ready(m_ready),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we(mem_we),
      .mem_rdata(mem_rdata),
      .led(led)
    );

    // Synchronous RAM environment, one cycle read latency.
    logic [7:0] ram_mem [int];
    always @(posedge clk) begin
      logic [7:0] rd;
      rd = ram_mem.exists(int'(mem_addr)) ? ram_mem[int'(mem_addr)] : ram_init(mem_addr);
      if (mem_we) ram_mem[int'(mem_addr)] = mem_wdata;
      mem_rdata <= rd;
    end

    // Reference model: memory image, LED value, data owed to the CPU, pending RAM writes.
    logic [7:0]  ref_mem [int];
    logic [7:0]  exp_rdata;
    logic [3:0]  exp_led;
    logic [21:0] exp_wq [$];

    function automatic logic [7:0] model_read(input logic [15:0] a);
      if (a == IO_ADDR) return {4'h0, exp_led};
      return ref_mem.exists(int'(a[13:0])) ? ref_mem[int'(a[13:0])] : ram_init(a[13:0]);
    endfunction

    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d, input logic commit);
      cpu_wr    = wr;
      cpu_addr  = a;
      cpu_wdata = d;
      if (wr) begin
        exp_rdata = d;
        if (a == IO_ADDR) begin
          exp_led = d[3:0];
        end else begin
          exp_wq.push_back({a[13:0], d});
          if (commit) ref_mem[int'(a[13:0])] = d;
        end
      end else begin
        exp_rdata = model_read(a);
      end
    endtask

    task automatic wait_ready(input int k_start, input int exp_lat, input string name);
      int k;
      @(negedge clk);
      k = k_start;
      while (!m_ready && k < MAX_WAIT) begin
        @(negedge clk);
        k++;
      end
      check(gi, {name, " latency"}, 64'(k), 64'(exp_lat));
      #1;
    endtask

    task automatic access(input logic wr, input logic [15:0] a, input logic [7:0] d, input string name);
      issue(wr, a, d, 1'b1);
      wait_ready(0, wr ? WR_LAT : RD_LAT, name);
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
      forever begin
        @(negedge clk);
        if (!locked) begin
          check(gi, "outputs in reset",
                64'({m_ready, cpu_rdata, mem_addr, mem_wdata, mem_we, led}), 64'(0));
        end else begin
          check(gi, "led", 64'(led), 64'(exp_led));
          if (m_ready) check(gi, "cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
          if (mem_we) begin
            check(gi, "mem_we pending", 64'(mem_we), 64'(exp_wq.size() > 0));
            if (exp_wq.size() > 0) begin
              check(gi, "mem write addr/data", 64'({mem_addr, mem_wdata}), 64'(exp_wq[0]));
              void'(exp_wq.pop_front());
            end
          end
        end
      end
    end

    // Stimulus: directed scenarios, then randomized accesses.
    initial begin
      locked    = 1'b1;
      cpu_wr    = 1'b0;
      cpu_addr  = 16'h0010;
      cpu_wdata = 8'h00;
      exp_led   = 4'h0;
      exp_rdata = 8'h00;
      #2 locked = 1'b0;
      repeat (3) @(negedge clk);
      #1;

      // Reset release starts a read of the current address.
      exp_rdata = model_read(16'h0010);
      locked = 1'b1;
      wait_ready(0, RD_LAT, "t1 reset read");
      check(gi, "t1 rdata", 64'(cpu_rdata), 64'(8'hA5));

      // Plain read of a new address.
      access(1'b0, 16'h0011, 8'h00, "t2 read");
      check(gi, "t2 rdata", 64'(cpu_rdata), 64'(8'h3C));

      // Level-held write performs exactly one RAM write.
      access(1'b1, 16'h0020, 8'h5A, "t3 write");
      check(gi, "t3 rdata", 64'(cpu_rdata), 64'(8'h5A));
      check(gi, "t3 write seen", 64'(exp_wq.size()), 64'(0));
      repeat (10) begin
        @(negedge clk);
        check(gi, "t3 ready held", 64'(m_ready), 64'(1));
        check(gi, "t3 no rewrite", 64'(mem_we), 64'(0));
      end
      #1;

      // LED register write and readback; RAM untouched.
      access(1'b1, IO_ADDR, 8'h0F, "t4 io write");
      check(gi, "t4 led", 64'(led), 64'(4'hF));
      access(1'b0, 16'h0000, 8'h00, "t4 read 0");
      access(1'b0, IO_ADDR, 8'h00, "t4 io read");
      check(gi, "t4 io rdata", 64'(cpu_rdata), 64'(8'h0F));

      // Address moved during the RAM latency: only the new address completes.
      issue(1'b0, 16'h0030, 8'h00, 1'b1);
      @(negedge clk);
      check(gi, "t5 busy", 64'(m_ready), 64'(0));
      #1;
      issue(1'b0, 16'h0031, 8'h00, 1'b1);
      wait_ready(1, 2 * RD_LAT, "t5 moved read");
      check(gi, "t5 rdata", 64'(cpu_rdata), 64'(8'hC3));

      // Reset during the write-done phase aborts the write.
      issue(1'b1, 16'h0040, 8'h77, 1'b0);
      @(negedge clk);
      #1;
      locked  = 1'b0;
      exp_led = 4'h0;
      cpu_wr  = 1'b0;
      #1;
      check(gi, "t6 async reset",
            64'({m_ready, cpu_rdata, mem_addr, mem_wdata, mem_we, led}), 64'(0));
      check(gi, "t6 write pulse seen", 64'(exp_wq.size()), 64'(0));
      repeat (2) @(negedge clk);
      #1;
      exp_rdata = model_read(16'h0040);
      locked = 1'b1;
      wait_ready(0, RD_LAT, "t6 reset read");
      check(gi, "t6 led", 64'(led), 64'(4'h0));

      // Randomized accesses, always honouring the address hold rule.
      for (int t = 0; t < N_RAND; t++) begin
        logic [15:0] a;
        logic [7:0]  d;
        logic        wr;
        int          r;
        do begin
          r = int'($urandom_range(0, 9));
          if (r == 0)      a = IO_ADDR;
          else if (r == 1) a = ($urandom_range(0, 1) == 0) ? 16'h3FFF : 16'h7FFF;
          else             a = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 3)) << 14);
        end while (a == cpu_addr);
        d  = 8'($urandom);
        wr = ($urandom_range(0, 2) == 0);
        access(wr, a, d, "rand");
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          #1;
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check(0, "all instances finished",
          64'({g_inst[0].done, g_inst[1].done, g_inst[2].done}), 64'(3'b111));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the 8-bit CPU bus: 16-bit address, 8-bit write data, write strobe, 8-bit read data, and the m_ready handshake.
- Serves CPU accesses from a synchronous on-chip RAM with a 1-cycle read latency.
- Inserts programmable wait states and deasserts m_ready until data is valid or a write has committed.
- Also decodes one I/O address that drives the board LEDs. Sits between the processor and the RAM/LED pins in the top level.

Parameters:
- ADDR_W, 14, RAM address width; cpu_addr[ADDR_W-1:0] goes to the RAM, upper bits alias.
- WAIT_STATES, 0, extra cycles (0..15) added to every access before m_ready rises.
- IO_ADDR, 16'hFFFF, full 16-bit address of the LED register; it takes precedence over RAM.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- locked  in  1  asynchronous active-low reset; 0 = reset.
- cpu_addr  in  16  CPU address, held stable by the CPU while m_ready=0.
- cpu_wdata  in  8  CPU write data.
- cpu_wr  in  1  CPU write request, level.
- cpu_rdata  out  8  read data to the CPU; valid while m_ready=1.
- m_ready  out  1  1 = last access complete and bus idle.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_wdata  out  8  registered RAM write data.
- mem_we  out  1  RAM write enable, one-cycle pulse.
- mem_rdata  in  8  RAM registered output; valid 1 clk after mem_addr is sampled.
- led  out  4  LED register.

Behaviour:
- Reset (locked=0, async, immediate, also mid-access):
  - m_ready=0, cpu_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, led=0.
  - state=IDLE, last_addr=16'h0000, wr_done=0, force=1.
  - force=1 makes the first IDLE cycle after release start a read of the current cpu_addr.
- States:
  - IDLE: m_ready held at its current value. Evaluated every edge, in priority order:
    1. Write: cpu_wr=1 and wr_done=0.
       - RAM target: mem_addr<=cpu_addr[ADDR_W-1:0], mem_wdata<=cpu_wdata, mem_we<=1.
       - IO target (cpu_addr==IO_ADDR): led<=cpu_wdata[3:0], mem_we stays 0.
       - Also: cpu_rdata<=cpu_wdata, last_addr<=cpu_addr, m_ready<=0, cnt<=WAIT_STATES, go to WDONE.
    2. Read: cpu_addr!=last_addr or force=1.
       - m_ready<=0, mem_addr<=cpu_addr[ADDR_W-1:0], last_addr<=cpu_addr, force<=0, cnt<=WAIT_STATES, go to RLAT.
    3. Otherwise stay in IDLE.
  - wr_done is cleared whenever cpu_wr=0 or cpu_addr!=last_addr. A level-held cpu_wr therefore performs exactly one write per address.
  - RLAT: one RAM latency cycle.
    - If cnt=0, go to CAPT; otherwise cnt<=cnt-1 and stay.
  - CAPT:
    - If cpu_addr!=last_addr (CPU violated hold): reissue the read as in IDLE, keep m_ready=0, go to RLAT.
    - Otherwise: cpu_rdata<=mem_rdata, or {4'h0,led} when last_addr==IO_ADDR; m_ready<=1; go to IDLE.
  - WDONE:
    - mem_we<=0 at the first edge in this state.
    - If cnt=0: wr_done<=1, m_ready<=1, go to IDLE. Otherwise cnt<=cnt-1.
- Latency (E0 = the edge at which IDLE accepts the request):
  - Read: m_ready rises at E(2+WAIT_STATES).
  - Write: m_ready rises at E(1+WAIT_STATES).
  - mem_we is high for exactly the cycle between E0 and E1.
- A simultaneous address change and write counts as a write: the write has priority.
- cpu_addr changes during RLAT or WDONE are ignored until CAPT or IDLE. m_ready never pulses high with data for a stale address.
- A back-to-back request at the edge where m_ready rose is accepted at the next edge. Minimum m_ready-high time is 1 cycle.

Test Plan:
1. Reset release with cpu_addr=0x0010, RAM[0x10]=0xA5, WAIT_STATES=0 -> m_ready=0 throughout reset; m_ready=1 and cpu_rdata=0xA5 two edges after locked rises.
2. cpu_addr 0x0010->0x0011 (RAM=0x3C) with WAIT_STATES=3 -> m_ready low for exactly 5 cycles, then cpu_rdata=0x3C.
3. cpu_wr held high 10 cycles, addr 0x0020, data 0x5A -> exactly one mem_we pulse (addr 0x20, data 0x5A), m_ready back high at E1, cpu_rdata=0x5A, no second write.
4. Write 0x0F to 0xFFFF, then read 0x0000 and read back 0xFFFF -> led=4'hF, mem_we never asserted, readback cpu_rdata=0x0F.
5. Address changed from 0x0030 to 0x0031 during RLAT (WAIT_STATES=2) -> no m_ready pulse for 0x0030; m_ready rises with RAM[0x31].
6. locked pulsed low during WDONE -> all outputs zero immediately; after release, read of current cpu_addr completes normally; led=0.
